// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws -- byte-addressed data memory with a MOV/MOC handshake,
// programmable wait states, big-endian byte/halfword/word/doubleword
// accesses, optional load sign extension and alignment checking.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   mov        request valid (level, held until the final moc)
//   read_write 1 = read, 0 = write
//   address    byte address of the first (most significant) byte
//   data_in    write data; byte uses [7:0], halfword [15:0]
//   data_type  00 byte, 01 halfword, 10 word, 11 doubleword (two beats)
//   signed_ld  1 = sign-extend byte/halfword reads
//   data_out   read data, held until the next completed read
//   moc        one-cycle completion pulse per beat
//   err        misalignment flag, valid with moc
//   busy       high from request capture until back in IDLE
//
// Optional build macro: MEM_CTRL_TRACE_EN -- prints one line per executed
// beat. Functional behaviour is identical with or without it.
module mem_ctrl_ws #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mov,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    input  logic [1:0]        data_type,
    input  logic              signed_ld,
    output logic [31:0]       data_out,
    output logic              moc,
    output logic              err,
    output logic              busy
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic [1:0] DT_BYTE  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_WORD  = 2'b10;
    localparam logic [1:0] DT_DWORD = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t            state_reg, state_next;
    logic              rw_reg, sgn_reg, beat_reg;
    logic [1:0]        dt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        cnt_reg;

    // Contents are deliberately not reset: the array is plain storage.
    logic [7:0] mem [0:DEPTH-1];

    logic              exec, misalign, more_beat;
    logic [ADDR_W-1:0] ba, a1, a2, a3;
    logic [7:0]        m0, m1, m2, m3;
    logic [31:0]       rd_data;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mov) state_next = WAIT;
            WAIT:    if (exec && !more_beat) state_next = DONE;
            DONE:    if (!mov) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / beat decode logic
    always_comb begin
        busy = (state_reg != IDLE);
        // A beat executes on the edge where the wait counter has run out.
        exec = (state_reg == WAIT) && (cnt_reg == 4'd0);
        case (dt_reg)
            DT_HALF:  misalign = addr_reg[0];
            DT_WORD:  misalign = |addr_reg[1:0];
            DT_DWORD: misalign = |addr_reg[2:0];
            default:  misalign = 1'b0;
        endcase
        // Doubleword second beat sits four bytes on; offsets wrap naturally.
        ba = beat_reg ? addr_reg + ADDR_W'(4) : addr_reg;
        a1 = ba + ADDR_W'(1);
        a2 = ba + ADDR_W'(2);
        a3 = ba + ADDR_W'(3);
        m0 = mem[ba];
        m1 = mem[a1];
        m2 = mem[a2];
        m3 = mem[a3];
        case (dt_reg)
            DT_BYTE: rd_data = {{24{sgn_reg & m0[7]}}, m0};
            DT_HALF: rd_data = {{16{sgn_reg & m0[7]}}, m0, m1};
            default: rd_data = {m0, m1, m2, m3};
        endcase
        more_beat = exec && !misalign && (dt_reg == DT_DWORD) && !beat_reg;
    end

    // Request capture, wait counting and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_reg   <= 1'b0;
            sgn_reg  <= 1'b0;
            beat_reg <= 1'b0;
            dt_reg   <= DT_BYTE;
            addr_reg <= '0;
            cnt_reg  <= 4'd0;
            data_out <= 32'd0;
            moc      <= 1'b0;
            err      <= 1'b0;
        end else begin
            moc <= exec;
            err <= exec && misalign;
            if (state_reg == IDLE && mov) begin
                rw_reg   <= read_write;
                sgn_reg  <= signed_ld;
                dt_reg   <= data_type;
                addr_reg <= address;
                cnt_reg  <= WS;
                beat_reg <= 1'b0;
            end else if (state_reg == WAIT) begin
                if (!exec) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end else if (more_beat) begin
                    beat_reg <= 1'b1;
                    cnt_reg  <= WS;
                end
            end
            if (exec && rw_reg && !misalign) data_out <= rd_data;
        end
    end

    // Memory write port: data_in is taken as it stands on the execution edge.
    always_ff @(posedge clk) begin
        if (exec && !rw_reg && !misalign) begin
            case (dt_reg)
                DT_BYTE: mem[ba] <= data_in[7:0];
                DT_HALF: begin
                    mem[ba] <= data_in[15:8];
                    mem[a1] <= data_in[7:0];
                end
                default: begin
                    mem[ba] <= data_in[31:24];
                    mem[a1] <= data_in[23:16];
                    mem[a2] <= data_in[15:8];
                    mem[a3] <= data_in[7:0];
                end
            endcase
        end
    end

`ifdef MEM_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (reset_n && exec)
            $display("%0t mem_ctrl_ws %s dt=%0d beat=%0d addr=%h data=%h err=%0b",
                     $time, rw_reg ? "R" : "W", dt_reg, beat_reg, ba,
                     rw_reg ? rd_data : data_in, misalign);
    end
`endif

endmodule

// File: tb/tb_mem_ctrl_ws.sv
// Self-checking bench for mem_ctrl_ws (ADDR_W=8, WAIT_STATES=1). A byte-array
// reference model computes expected reads, alignment errors and beat counts.
module tb_mem_ctrl_ws;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mov = 1'b0;
    logic        read_write = 1'b0;
    logic [7:0]  address = 8'd0;
    logic [31:0] data_in = 32'd0;
    logic [1:0]  data_type = 2'd0;
    logic        signed_ld = 1'b0;
    logic [31:0] data_out;
    logic        moc, err, busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mm [0:255];
    logic [31:0] exp_dout = 32'd0;

    mem_ctrl_ws #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n), .mov(mov), .read_write(read_write),
        .address(address), .data_in(data_in), .data_type(data_type),
        .signed_ld(signed_ld), .data_out(data_out), .moc(moc), .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input int dt);
        return (dt == 0) ? 1 : (dt == 1) ? 2 : 4;
    endfunction

    function automatic bit mis(input int a, input int dt);
        case (dt)
            1:       return (a % 2) != 0;
            2:       return (a % 4) != 0;
            3:       return (a % 8) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input int a, input int dt, input bit sg);
        longint v = 0;
        int n = nbytes(dt);
        for (int i = 0; i < n; i++) v = v * 256 + longint'(mm[(a + i) % 256]);
        if (sg && dt < 2 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic mwrite(input int a, input int dt, input logic [31:0] w);
        int n = nbytes(dt);
        for (int i = 0; i < n; i++) mm[(a + i) % 256] = 8'(w >> (8 * (n - 1 - i)));
    endtask

    // ---------------- transaction driver (no checking) ----------------
    task automatic run_op(input logic rw, input logic [7:0] a, input logic [1:0] dt,
                          input logic sg, input logic [31:0] w0, input logic [31:0] w1,
                          output int n_moc, output int n_err, output int t0, output int t1,
                          output logic [31:0] d0, output logic [31:0] d1,
                          output logic busy_hold, output logic busy_rel);
        n_moc = 0; n_err = 0; t0 = -1; t1 = -1; d0 = 32'd0; d1 = 32'd0;
        @(negedge clk);
        mov = 1'b1; read_write = rw; address = a; data_type = dt;
        signed_ld = sg; data_in = w0;
        @(posedge clk); #1;
        // Inputs other than data_in must be ignored after capture.
        read_write = 1'($urandom); address = 8'($urandom);
        data_type = 2'($urandom); signed_ld = 1'($urandom);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (err) n_err++;
            if (moc) begin
                if (n_moc == 0) begin t0 = k; d0 = data_out; data_in = w1; end
                else if (n_moc == 1) begin t1 = k; d1 = data_out; end
                n_moc++;
            end
        end
        busy_hold = busy;
        @(negedge clk); mov = 1'b0;
        @(posedge clk); #1;
        busy_rel = busy;
        $display("op rw=%0b addr=%h dt=%0d sg=%0b w0=%h w1=%h mocs=%0d errs=%0d d0=%h d1=%h",
                 rw, a, dt, sg, w0, w1, n_moc, n_err, d0, d1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        checks++; if (moc !== 1'b0) begin failures++; $display("FAIL reset_moc got=%b want=0", moc); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk); reset_n = 1'b1;
        exp_dout = 32'd0;
    endtask

    task automatic test_word();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        logic [7:0] eb [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_op(1'b0, 8'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(16, 2, 32'hDEADBEEF);
        checks++; if (n !== 1) begin failures++; $display("FAIL word_wr_mocs got=%0d want=1", n); end
        checks++; if (t0 !== WS + 1) begin failures++; $display("FAIL word_wr_latency got=%0d want=%0d", t0, WS + 1); end
        checks++; if (ne !== 0) begin failures++; $display("FAIL word_wr_err got=%0d want=0", ne); end
        checks++; if (bh !== 1'b1) begin failures++; $display("FAIL word_wr_busy_hold got=%b want=1", bh); end
        checks++; if (br !== 1'b0) begin failures++; $display("FAIL word_wr_busy_rel got=%b want=0", br); end
        run_op(1'b1, 8'h10, 2'd2, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (t0 !== WS + 1) begin failures++; $display("FAIL word_rd_latency got=%0d want=%0d", t0, WS + 1); end
        checks++; if (d0 !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rd_data got=%h want=deadbeef", d0); end
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 8'(16 + i), 2'd0, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
            checks++; if (d0 !== {24'h0, eb[i]}) begin failures++; $display("FAIL word_byte_rd[%0d] got=%h want=%h", i, d0, eb[i]); end
        end
        exp_dout = {24'h0, eb[3]};
    endtask

    task automatic test_sign();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        run_op(1'b0, 8'h21, 2'd0, 1'b0, 32'hFFFFFF80, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(33, 0, 32'h80);
        checks++; if (d0 !== exp_dout) begin failures++; $display("FAIL sign_wr_dout_held got=%h want=%h", d0, exp_dout); end
        run_op(1'b1, 8'h21, 2'd0, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== 32'h00000080) begin failures++; $display("FAIL byte_zext got=%h want=00000080", d0); end
        run_op(1'b1, 8'h21, 2'd0, 1'b1, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_sext got=%h want=ffffff80", d0); end
        run_op(1'b0, 8'h22, 2'd1, 1'b0, 32'h12348001, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(34, 1, 32'h8001);
        run_op(1'b1, 8'h22, 2'd1, 1'b1, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== 32'hFFFF8001) begin failures++; $display("FAIL half_sext got=%h want=ffff8001", d0); end
        run_op(1'b1, 8'h22, 2'd1, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== 32'h00008001) begin failures++; $display("FAIL half_zext got=%h want=00008001", d0); end
        exp_dout = 32'h00008001;
    endtask

    task automatic test_dword();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        run_op(1'b0, 8'h30, 2'd3, 1'b0, 32'h11223344, 32'h55667788, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(48, 2, 32'h11223344); mwrite(52, 2, 32'h55667788);
        checks++; if (n !== 2) begin failures++; $display("FAIL dw_wr_mocs got=%0d want=2", n); end
        checks++; if (t1 !== 2 * WS + 2) begin failures++; $display("FAIL dw_wr_beat1_time got=%0d want=%0d", t1, 2 * WS + 2); end
        checks++; if (bh !== 1'b1 || br !== 1'b0) begin failures++; $display("FAIL dw_wr_busy got=%b%b want=10", bh, br); end
        run_op(1'b1, 8'h30, 2'd3, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (n !== 2) begin failures++; $display("FAIL dw_rd_mocs got=%0d want=2", n); end
        checks++; if (d0 !== 32'h11223344) begin failures++; $display("FAIL dw_rd_beat0 got=%h want=11223344", d0); end
        checks++; if (d1 !== 32'h55667788) begin failures++; $display("FAIL dw_rd_beat1 got=%h want=55667788", d1); end
        checks++; if (t0 !== WS + 1 || t1 !== 2 * WS + 2) begin failures++; $display("FAIL dw_rd_times got=%0d,%0d want=%0d,%0d", t0, t1, WS + 1, 2 * WS + 2); end
        exp_dout = 32'h55667788;
    endtask

    task automatic test_misalign();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        logic [31:0] w = $urandom;
        logic [31:0] b = $urandom;
        run_op(1'b0, 8'h40, 2'd2, 1'b0, w, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(64, 2, w);
        run_op(1'b0, 8'h44, 2'd0, 1'b0, b, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(68, 0, b);
        run_op(1'b1, 8'h40, 2'd2, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        exp_dout = mread(64, 2, 1'b0);
        checks++; if (d0 !== exp_dout) begin failures++; $display("FAIL mis_prime_rd got=%h want=%h", d0, exp_dout); end
        run_op(1'b1, 8'h41, 2'd2, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (n !== 1 || ne !== 1) begin failures++; $display("FAIL mis_word_pulses got=moc%0d err%0d want=moc1 err1", n, ne); end
        checks++; if (t0 !== WS + 1) begin failures++; $display("FAIL mis_word_latency got=%0d want=%0d", t0, WS + 1); end
        checks++; if (d0 !== exp_dout) begin failures++; $display("FAIL mis_word_dout got=%h want=%h", d0, exp_dout); end
        run_op(1'b0, 8'h43, 2'd1, 1'b0, ~w, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (n !== 1 || ne !== 1) begin failures++; $display("FAIL mis_half_pulses got=moc%0d err%0d want=moc1 err1", n, ne); end
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, 8'(64 + i), 2'd0, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
            checks++; if (d0 !== mread(64 + i, 0, 1'b0)) begin failures++; $display("FAIL mis_bytes[%0d] got=%h want=%h", i, d0, mread(64 + i, 0, 1'b0)); end
        end
        exp_dout = mread(68, 0, 1'b0);
    endtask

    task automatic test_wrap();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        logic [7:0] eb [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_op(1'b0, 8'hFC, 2'd2, 1'b0, 32'hA1B2C3D4, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(252, 2, 32'hA1B2C3D4);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 8'(252 + i), 2'd0, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
            checks++; if (d0 !== {24'h0, eb[i]}) begin failures++; $display("FAIL wrap_byte[%0d] got=%h want=%h", i, d0, eb[i]); end
        end
        exp_dout = {24'h0, eb[3]};
    endtask

    task automatic test_random();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w = $urandom;
            run_op(1'b0, 8'(4 * i), 2'd2, 1'b0, w, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
            mwrite(4 * i, 2, w);
        end
        for (int i = 0; i < 60; i++) begin
            logic rw = 1'($urandom);
            int dt = $urandom_range(0, 3);
            int a = $urandom_range(0, 255);
            logic sg = 1'($urandom);
            logic [31:0] w0 = $urandom;
            logic [31:0] w1 = $urandom;
            bit m; int en; logic [31:0] e0, e1;
            if ($urandom_range(0, 1) == 1) a = a & ~7;
            m = mis(a, dt);
            en = (!m && dt == 3) ? 2 : 1;
            e0 = exp_dout; e1 = exp_dout;
            if (rw && !m) begin
                e0 = mread(a, dt, sg);
                if (dt == 3) e1 = mread(a + 4, 2, 1'b0);
                exp_dout = (dt == 3) ? e1 : e0;
            end
            run_op(rw, 8'(a), 2'(dt), sg, w0, w1, n, ne, t0, t1, d0, d1, bh, br);
            if (!rw && !m) begin
                if (dt == 3) begin mwrite(a, 2, w0); mwrite(a + 4, 2, w1); end
                else mwrite(a, dt, w0);
            end
            checks++; if (n !== en) begin failures++; $display("FAIL rnd[%0d]_mocs got=%0d want=%0d", i, n, en); end
            checks++; if (ne !== int'(m)) begin failures++; $display("FAIL rnd[%0d]_err got=%0d want=%0d", i, ne, m); end
            checks++; if (t0 !== WS + 1) begin failures++; $display("FAIL rnd[%0d]_latency got=%0d want=%0d", i, t0, WS + 1); end
            checks++; if (d0 !== e0) begin failures++; $display("FAIL rnd[%0d]_d0 got=%h want=%h", i, d0, e0); end
            if (en == 2) begin
                checks++; if (d1 !== e1 || t1 !== 2 * WS + 2) begin failures++; $display("FAIL rnd[%0d]_beat1 got=%h@%0d want=%h@%0d", i, d1, t1, e1, 2 * WS + 2); end
            end
            checks++; if (bh !== 1'b1 || br !== 1'b0) begin failures++; $display("FAIL rnd[%0d]_busy got=%b%b want=10", i, bh, br); end
        end
    endtask

    task automatic test_reset_mid();
        int n, ne, t0, t1; logic [31:0] d0, d1; logic bh, br;
        logic [31:0] v = $urandom | 32'h1;
        int seen = 0;
        run_op(1'b0, 8'h50, 2'd2, 1'b0, v, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        mwrite(80, 2, v);
        run_op(1'b1, 8'h50, 2'd2, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== v) begin failures++; $display("FAIL rstmid_prime got=%h want=%h", d0, v); end
        @(negedge clk);
        mov = 1'b1; read_write = 1'b0; address = 8'h50; data_type = 2'd2; data_in = ~v;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL rstmid_dout got=%h want=0", data_out); end
        checks++; if (moc !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rstmid_moc_err got=%b%b want=00", moc, err); end
        mov = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        exp_dout = 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (moc) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_moc got=%0d want=0", seen); end
        run_op(1'b1, 8'h50, 2'd2, 1'b0, 32'h0, 32'h0, n, ne, t0, t1, d0, d1, bh, br);
        checks++; if (d0 !== v) begin failures++; $display("FAIL rstmid_mem_kept got=%h want=%h", d0, v); end
        exp_dout = v;
    endtask

    initial begin
        test_reset();
        test_word();
        test_sign();
        test_dword();
        test_misalign();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
